// File: rtl/prog_fetch_seq.sv
// Program counter and fetch sequencer in front of the synchronous program ROM.
// Presents the PC as the ROM address, remembers which address the ROM output
// belongs to, and steps INIT -> FETCH -> EXEC (-> INTR) so the instruction
// register is flagged valid only once the ROM data has arrived.
module prog_fetch_seq #(
  parameter int unsigned        ADDR_W       = 10,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(10'h000),
  parameter logic [ADDR_W-1:0] ISR_VECTOR   = ADDR_W'(10'h3FF)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EXEC_DONE,
  input  logic [1:0]        PC_SEL,
  input  logic [ADDR_W-1:0] FROM_IMMED,
  input  logic [ADDR_W-1:0] FROM_STACK,
  input  logic              INT_REQ,
  input  logic              INT_EN,
  output logic [ADDR_W-1:0] PROG_ADDR,
  output logic              IR_VALID,
  output logic [ADDR_W-1:0] CUR_ADDR,
  output logic [ADDR_W-1:0] RET_ADDR,
  output logic              INT_ACK,
  output logic [1:0]        STATE
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_INTR  = 2'b11
  } state_t;

  localparam logic [1:0] SEL_INC   = 2'b00;
  localparam logic [1:0] SEL_IMMED = 2'b01;
  localparam logic [1:0] SEL_STACK = 2'b10;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] ret_q, ret_d;
  logic              ir_valid_q, ir_valid_d;
  logic              int_ack_q, int_ack_d;
  logic [ADDR_W-1:0] next_pc;
  logic              int_take;

  // Candidate next PC from the decoder's selection; increment wraps naturally
  always_comb begin
    next_pc = ISR_VECTOR;
    case (PC_SEL)
      SEL_INC:   next_pc = pc_q + ADDR_W'(1);
      SEL_IMMED: next_pc = FROM_IMMED;
      SEL_STACK: next_pc = FROM_STACK;
      default:   next_pc = ISR_VECTOR;
    endcase
  end

  assign int_take = INT_REQ & INT_EN;

  // Next-state, PC and address-tracking logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cur_d   = cur_q;
    ret_d   = ret_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // ROM captures PROG_ADDR on this edge; remember which address it was
        cur_d   = pc_q;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (EXEC_DONE) begin
          if (int_take) begin
            ret_d   = next_pc;
            pc_d    = ISR_VECTOR;
            state_d = ST_INTR;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_INTR: begin
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    ir_valid_d = (state_d == ST_EXEC);
    int_ack_d  = (state_d == ST_INTR);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_INIT;
      pc_q       <= RESET_VECTOR;
      cur_q      <= '0;
      ret_q      <= '0;
      ir_valid_q <= 1'b0;
      int_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cur_q      <= cur_d;
      ret_q      <= ret_d;
      ir_valid_q <= ir_valid_d;
      int_ack_q  <= int_ack_d;
    end
  end

  assign PROG_ADDR = pc_q;
  assign CUR_ADDR  = cur_q;
  assign RET_ADDR  = ret_q;
  assign IR_VALID  = ir_valid_q;
  assign INT_ACK   = int_ack_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_prog_fetch_seq.sv
// Self-checking bench for prog_fetch_seq: an instruction-level model tracks
// the PC and return address and each instruction is walked through its phases.
module tb_prog_fetch_seq;

  localparam int unsigned ADDR_W = 10;
  localparam logic [9:0]  ISR    = 10'h3FF;
  localparam logic [1:0]  S_INIT = 2'b00, S_FETCH = 2'b01, S_EXEC = 2'b10, S_INTR = 2'b11;

  logic              clk = 1'b0;
  logic              rst, exec_done, int_req, int_en;
  logic [1:0]        pc_sel;
  logic [ADDR_W-1:0] from_immed, from_stack;
  logic [ADDR_W-1:0] prog_addr, cur_addr, ret_addr;
  logic              ir_valid, int_ack;
  logic [1:0]        state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: PC of the instruction being fetched and latched return address
  logic [9:0] m_pc;
  logic [9:0] m_ret;

  prog_fetch_seq dut (
    .CLK(clk), .RST(rst), .EXEC_DONE(exec_done), .PC_SEL(pc_sel),
    .FROM_IMMED(from_immed), .FROM_STACK(from_stack),
    .INT_REQ(int_req), .INT_EN(int_en),
    .PROG_ADDR(prog_addr), .IR_VALID(ir_valid), .CUR_ADDR(cur_addr),
    .RET_ADDR(ret_addr), .INT_ACK(int_ack), .STATE(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in FETCH and leaves the DUT in the next FETCH
  task automatic run_instr(input int hold, input logic [1:0] sel, input logic [9:0] imm,
                           input logic [9:0] stk, input logic req, input logic en);
    logic [9:0] nxt;
    logic       taken;
    n_tests++;
    if (state !== S_FETCH || prog_addr !== m_pc || ir_valid !== 1'b0 || int_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch: state=%b addr=%h irv=%b ack=%b, want state=01 addr=%h irv=0 ack=0",
               state, prog_addr, ir_valid, int_ack, m_pc);
    end
    // Outside EXEC these are don't-care: drive junk to prove it
    exec_done = 1'b1; pc_sel = 2'($urandom); int_req = 1'b1; int_en = 1'b1;
    from_immed = 10'($urandom); from_stack = 10'($urandom);
    step();
    for (int h = 0; h <= hold; h++) begin
      n_tests++;
      if (state !== S_EXEC || ir_valid !== 1'b1 || cur_addr !== m_pc || prog_addr !== m_pc ||
          int_ack !== 1'b0 || ret_addr !== m_ret) begin
        n_fail++;
        $display("FAIL exec[%0d]: state=%b irv=%b cur=%h addr=%h ack=%b ret=%h, want 10 1 %h %h 0 %h",
                 h, state, ir_valid, cur_addr, prog_addr, int_ack, ret_addr, m_pc, m_pc, m_ret);
      end
      if (h < hold) begin
        exec_done = 1'b0; int_req = 1'($urandom); int_en = 1'($urandom);
        pc_sel = 2'($urandom);
        step();
      end
    end
    exec_done = 1'b1; pc_sel = sel; from_immed = imm; from_stack = stk;
    int_req = req; int_en = en;
    case (sel)
      2'b00:   nxt = m_pc + 10'd1;
      2'b01:   nxt = imm;
      2'b10:   nxt = stk;
      default: nxt = ISR;
    endcase
    taken = req && en;
    if (taken) begin
      m_ret = nxt;
      m_pc  = ISR;
    end else begin
      m_pc = nxt;
    end
    step();
    exec_done = 1'b0; int_req = 1'b0;
    if (taken) begin
      n_tests++;
      if (state !== S_INTR || int_ack !== 1'b1 || ret_addr !== m_ret || prog_addr !== ISR ||
          ir_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL intr: state=%b ack=%b ret=%h addr=%h irv=%b, want 11 1 %h %h 0",
                 state, int_ack, ret_addr, prog_addr, ir_valid, m_ret, ISR);
      end
      step();
    end
    n_tests++;
    if (state !== S_FETCH || int_ack !== 1'b0 || ret_addr !== m_ret) begin
      n_fail++;
      $display("FAIL post: state=%b ack=%b ret=%h, want 01 0 %h", state, int_ack, ret_addr, m_ret);
    end
  endtask

  task automatic check_reset_state(input string tag);
    n_tests++;
    if (state !== S_INIT || prog_addr !== 10'h000 || cur_addr !== 10'h000 ||
        ret_addr !== 10'h000 || ir_valid !== 1'b0 || int_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: state=%b addr=%h cur=%h ret=%h irv=%b ack=%b, want 00 000 000 000 0 0",
               tag, state, prog_addr, cur_addr, ret_addr, ir_valid, int_ack);
    end
  endtask

  // Releases reset from INIT and lands in the first FETCH
  task automatic leave_reset();
    rst = 1'b0;
    m_pc = 10'h000; m_ret = 10'h000;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; exec_done = 1'b0; pc_sel = 2'b00; int_req = 1'b0; int_en = 1'b0;
    from_immed = '0; from_stack = '0;
    step(); step();
    check_reset_state("reset");
    leave_reset();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) run_instr(0, 2'b00, 10'h0, 10'h0, 1'b0, 1'b0);
  endtask

  task automatic test_branch_return();
    run_instr(0, 2'b01, 10'h155, 10'h0, 1'b0, 1'b0);
    run_instr(0, 2'b10, 10'h0, 10'h020, 1'b0, 1'b0);
    n_tests++;
    if (prog_addr !== 10'h020) begin
      n_fail++;
      $display("FAIL return_addr: addr=%h want 020", prog_addr);
    end
  endtask

  task automatic test_multicycle();
    run_instr(0, 2'b01, 10'h010, 10'h0, 1'b0, 1'b0);
    run_instr(4, 2'b00, 10'h0, 10'h0, 1'b0, 1'b0);
    n_tests++;
    if (prog_addr !== 10'h011) begin
      n_fail++;
      $display("FAIL multicycle_next: addr=%h want 011", prog_addr);
    end
  endtask

  task automatic test_interrupt();
    run_instr(0, 2'b01, 10'h0A0, 10'h0, 1'b0, 1'b0);
    run_instr(0, 2'b00, 10'h0, 10'h0, 1'b1, 1'b1);
    n_tests++;
    if (ret_addr !== 10'h0A1 || prog_addr !== 10'h3FF) begin
      n_fail++;
      $display("FAIL int_entry: ret=%h addr=%h want 0a1 3ff", ret_addr, prog_addr);
    end
    // Selecting the ISR vector without a taken interrupt: no ack, no RET update
    run_instr(0, 2'b11, 10'h0, 10'h0, 1'b1, 1'b0);
  endtask

  task automatic test_masked_wrap();
    run_instr(0, 2'b01, 10'h3FF, 10'h0, 1'b0, 1'b0);
    run_instr(1, 2'b00, 10'h0, 10'h0, 1'b1, 1'b0);
    n_tests++;
    if (prog_addr !== 10'h000 || ret_addr !== 10'h0A1) begin
      n_fail++;
      $display("FAIL wrap: addr=%h ret=%h want 000 0a1", prog_addr, ret_addr);
    end
  endtask

  task automatic test_reset_mid();
    run_instr(0, 2'b01, 10'h123, 10'h0, 1'b0, 1'b0);
    step();
    n_tests++;
    if (state !== S_EXEC || prog_addr !== 10'h123) begin
      n_fail++;
      $display("FAIL pre_rst_exec: state=%b addr=%h want 10 123", state, prog_addr);
    end
    rst = 1'b1; exec_done = 1'b1; int_req = 1'b1; int_en = 1'b1;
    step();
    check_reset_state("rst_in_exec");
    exec_done = 1'b0; int_req = 1'b0;
    leave_reset();
    run_instr(0, 2'b01, 10'h200, 10'h0, 1'b0, 1'b0);
    step();
    exec_done = 1'b1; pc_sel = 2'b00; int_req = 1'b1; int_en = 1'b1;
    step();
    exec_done = 1'b0; int_req = 1'b0;
    n_tests++;
    if (state !== S_INTR || int_ack !== 1'b1 || ret_addr !== 10'h201) begin
      n_fail++;
      $display("FAIL pre_rst_intr: state=%b ack=%b ret=%h want 11 1 201", state, int_ack, ret_addr);
    end
    rst = 1'b1;
    step();
    check_reset_state("rst_in_intr");
    leave_reset();
  endtask

  task automatic test_random();
    logic [1:0] sel;
    for (int i = 0; i < 150; i++) begin
      sel = 2'($urandom);
      run_instr(int'($urandom_range(0, 3)), sel, 10'($urandom), 10'($urandom),
                1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_return();
    test_multicycle();
    test_interrupt();
    test_masked_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
